// File: rtl/uart_prog_loader.sv
// Receives a length-prefixed program image over 8N1 UART and writes it word by word into imem.
// Each word is written the cycle after its 4th byte arrives; load_active frames the whole load.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              start,
  output logic              load_active,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err
);

  localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  HALF_CNT  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0]  LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [32:0]    MAX_WORDS = 33'(1) << ADDR_W;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {IDLE, LEN, DATA, DONE} ld_state_e;

  // ---------------------------------------------------------------- RX path
  logic            rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_vld_q, byte_vld_d;
  logic [7:0]      byte_dat_q, byte_dat_d;
  logic            frame_err_q, frame_err_d;

  // rx_s3_q is the previous synchronized sample, used only for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      rx_state_q  <= R_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      byte_vld_q  <= 1'b0;
      byte_dat_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      rx_s3_q     <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      byte_vld_q  <= byte_vld_d;
      byte_dat_q  <= byte_dat_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    byte_vld_d  = 1'b0;
    byte_dat_d  = byte_dat_q;
    frame_err_d = 1'b0;
    unique case (rx_state_q)
      R_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_state_d = R_START;
          rx_cnt_d   = '0;
        end
      end
      R_START: begin
        if (rx_cnt_q == HALF_CNT) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          // a start bit that is already gone by mid-bit was a glitch
          rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      R_DATA: begin
        if (rx_cnt_q == LAST_CNT) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      R_STOP: begin
        if (rx_cnt_q == LAST_CNT) begin
          rx_cnt_d   = '0;
          rx_state_d = R_IDLE;
          if (rx_s2_q) begin
            byte_vld_d = 1'b1;
            byte_dat_d = rx_shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- loader
  ld_state_e         ld_state_q, ld_state_d;
  logic              start_d_q;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              active_q, active_d;
  logic              arm;
  logic [31:0]       len_new;
  logic [ADDR_W:0]   word_cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state_q <= IDLE;
      start_d_q  <= 1'b0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      word_q     <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      ld_state_q <= ld_state_d;
      start_d_q  <= start;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      word_q     <= word_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      done_q     <= done_d;
      err_q      <= err_d;
      active_q   <= active_d;
    end
  end

  assign arm          = start && !start_d_q;
  assign len_new      = {byte_dat_q, len_q[31:8]};
  assign word_cnt_inc = word_cnt_q + (ADDR_W+1)'(1);

  always_comb begin
    ld_state_d = ld_state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    word_d     = word_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    done_d     = done_q;
    err_d      = err_q;
    active_d   = active_q;
    unique case (ld_state_q)
      IDLE, DONE: begin
        // received bytes are dropped here; only a start edge matters
        if (arm) begin
          ld_state_d = LEN;
          done_d     = 1'b0;
          err_d      = 1'b0;
          active_d   = 1'b1;
          byte_cnt_d = '0;
          len_d      = '0;
          word_d     = '0;
          word_cnt_d = '0;
          addr_d     = '0;
        end
      end
      LEN: begin
        if (frame_err_q) begin
          ld_state_d = IDLE;
          err_d      = 1'b1;
          active_d   = 1'b0;
          byte_cnt_d = '0;
          len_d      = '0;
        end else if (byte_vld_q) begin
          len_d      = len_new;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (len_new == 32'd0) begin
              ld_state_d = DONE;
              done_d     = 1'b1;
              active_d   = 1'b0;
            end else if ({1'b0, len_new} > MAX_WORDS) begin
              ld_state_d = IDLE;
              err_d      = 1'b1;
              active_d   = 1'b0;
            end else begin
              ld_state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        if (frame_err_q) begin
          ld_state_d = IDLE;
          err_d      = 1'b1;
          active_d   = 1'b0;
          byte_cnt_d = '0;
          word_d     = '0;
        end else if (byte_vld_q) begin
          word_d     = {byte_dat_q, word_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          we_d       = (byte_cnt_q == 2'd3);
        end
        if (we_q) begin
          word_cnt_d = word_cnt_inc;
          // the final write leaves the address on the last word, so it never wraps
          if (word_cnt_inc == len_q[ADDR_W:0]) begin
            ld_state_d = DONE;
            done_d     = 1'b1;
            active_d   = 1'b0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      default: ld_state_d = IDLE;
    endcase
  end

  assign load_active = active_q;
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = word_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed and randomized program loads driven over a bit-level UART model, checked against expected image.
module tb_uart_prog_loader;

  localparam int CPB = 4;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          start;
  logic          load_active;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          done;
  logic          err;

  int vectors     = 0;
  int miscompares = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  logic [31:0]   exp_words[$];

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rx(rx), .start(start),
    .load_active(load_active), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1 rx = b[i];
    end
    repeat (CPB) @(posedge clk); #1 rx = stop_bit;
    repeat (CPB) @(posedge clk); #1 rx = 1'b1;
    repeat (3*CPB) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic glitch();
    @(posedge clk); #1 rx = 1'b0;
    @(posedge clk); #1 rx = 1'b1;
    repeat (5*CPB) @(posedge clk);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    repeat (3) @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (load_active === 1'b1 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    #1 chk("wait_idle", 32'(load_active), 32'd0);
  endtask

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Reference outcome: word i of the image lands at address i, nothing else is written.
  task automatic verify_writes(input string tag);
    int n;
    chk({tag, "_count"}, 32'(wr_addr_q.size()), 32'(exp_words.size()));
    n = (wr_addr_q.size() < exp_words.size()) ? wr_addr_q.size() : exp_words.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'(i));
      chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_words[i]);
    end
  endtask

  task automatic do_load(input string tag, input int n);
    exp_words.delete();
    clear_obs();
    for (int i = 0; i < n; i++) exp_words.push_back($urandom);
    pulse_start();
    chk({tag, "_armed"}, 32'(load_active), 32'd1);
    send_word(32'(n));
    foreach (exp_words[i]) send_word(exp_words[i]);
    wait_idle();
    verify_writes(tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_active", 32'(load_active), 32'd0);
    chk("rst_we",     32'(imem_we), 32'd0);
    chk("rst_addr",   32'(imem_addr), 32'd0);
    chk("rst_wdata",  imem_wdata, 32'd0);
    chk("rst_done",   32'(done), 32'd0);
    chk("rst_err",    32'(err), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // nominal fixed image
    exp_words = '{32'h0010_0513, 32'h0000_0073};
    clear_obs();
    pulse_start();
    chk("nom_armed", 32'(load_active), 32'd1);
    send_word(32'd2);
    send_word(32'h0010_0513);
    send_word(32'h0000_0073);
    wait_idle();
    verify_writes("nom");
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_err",  32'(err), 32'd0);

    // randomized images, including the largest legal size
    do_load("rnd_a", $urandom_range(1, 15));
    do_load("rnd_b", $urandom_range(1, 15));
    do_load("max16", 16);

    // zero length
    exp_words.delete();
    clear_obs();
    pulse_start();
    send_word(32'd0);
    wait_idle();
    verify_writes("zero");
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_err",  32'(err), 32'd0);

    // oversize length
    clear_obs();
    pulse_start();
    send_word(32'd17);
    wait_idle();
    verify_writes("over");
    chk("over_err",  32'(err), 32'd1);
    chk("over_done", 32'(done), 32'd0);

    // bad stop bit on the second data byte
    clear_obs();
    pulse_start();
    send_word(32'd3);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (4) @(posedge clk); #1;
    chk("frm_err",    32'(err), 32'd1);
    chk("frm_active", 32'(load_active), 32'd0);
    verify_writes("frm");
    pulse_start();
    chk("frm_rearm_err",    32'(err), 32'd0);
    chk("frm_rearm_active", 32'(load_active), 32'd1);
    exp_words = '{$urandom};
    send_word(32'd1);
    send_word(exp_words[0]);
    wait_idle();
    verify_writes("frm_reload");

    // glitches and a start edge mid-load are ignored
    exp_words = '{$urandom, $urandom, $urandom};
    clear_obs();
    pulse_start();
    glitch();
    send_word(32'd3);
    send_word(exp_words[0]);
    pulse_start();
    chk("mid_start_active", 32'(load_active), 32'd1);
    send_byte(exp_words[1][7:0], 1'b1);
    glitch();
    send_byte(exp_words[1][15:8], 1'b1);
    send_byte(exp_words[1][23:16], 1'b1);
    send_byte(exp_words[1][31:24], 1'b1);
    send_word(exp_words[2]);
    wait_idle();
    verify_writes("glitch");
    chk("glitch_done", 32'(done), 32'd1);

    // traffic while finished produces nothing
    clear_obs();
    exp_words.delete();
    glitch();
    send_word(32'd1);
    send_word(32'hABCD_EF12);
    verify_writes("idle_traffic");
    chk("idle_done",   32'(done), 32'd1);
    chk("idle_active", 32'(load_active), 32'd0);

    // reset mid-load after one word
    exp_words = '{$urandom};
    clear_obs();
    pulse_start();
    send_word(32'd3);
    send_word(exp_words[0]);
    verify_writes("prerst");
    #3 rst = 1'b1;
    #1;
    chk("arst_active", 32'(load_active), 32'd0);
    chk("arst_we",     32'(imem_we), 32'd0);
    chk("arst_addr",   32'(imem_addr), 32'd0);
    chk("arst_wdata",  imem_wdata, 32'd0);
    chk("arst_done",   32'(done), 32'd0);
    chk("arst_err",    32'(err), 32'd0);
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    do_load("post_rst", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
